imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the instruction memory: receives a length-prefixed byte stream, packs bytes into
//  32-bit words and drives the Memory write port (waddr/wdata/wen) that the fetch stage leaves tied off.
//  Holds the core in reset (cpu_nrst low) while loading; releases it once the image is complete.
//  Sits between the host byte source (UART/bench) and the icache Memory instance, beside FETCH.
// PARAMETERS
//  BASE_ADDR  32'h0  address of first word written
//  ADDR_STEP  4      address increment per word (byte-addressed PC)
//  MAX_WORDS  256    largest accepted image length in words; longer header -> error
// PORTS
//  clk          in   1   clock
//  nrst         in   1   synchronous, active-low reset
//  start        in   1   re-arm pulse; honoured only in DONE or ERR
//  in_valid     in   1   byte source has a byte
//  in_data      in   8   stream byte
//  in_ready     out  1   loader accepts byte this cycle (transfer = in_valid & in_ready)
//  mem_waddr    out  32  instruction memory write address
//  mem_wdata    out  32  instruction memory write data
//  mem_wen      out  1   one-cycle write strobe
//  cpu_nrst     out  1   active-low reset to core; high only in DONE
//  done         out  1   image loaded
//  error        out  1   header length > MAX_WORDS
//  words_loaded out  16  words written since last header
// BEHAVIOUR
//  - Reset (nrst low at posedge, any state): state=HDR_LO, cpu_nrst=0, mem_wen=0, mem_waddr=0, mem_wdata=0,
//    done=0, error=0, words_loaded=0, byte/word counters cleared; partial word discarded, never written.
//  - Stream: len[7:0], len[15:8], then len*4 data bytes, each word little-endian (first byte = bits 7:0).
//  - in_ready is a function of state only (high in HDR_LO, HDR_HI, DATA); no combinational path from in_valid.
//  - HDR_LO: on transfer latch len[7:0] -> HDR_HI.
//  - HDR_HI: on transfer latch len[15:8]; len==0 -> DONE; len>MAX_WORDS -> ERR; else DATA, byte_cnt=0, word_idx=0.
//  - DATA: on transfer shift byte into word[8*byte_cnt +: 8]; byte_cnt 0..3; transfer at byte_cnt==3 -> WRITE.
//    Cycles with in_valid low: hold, no state change.
//  - WRITE (1 cycle, in_ready=0): mem_wen=1, mem_waddr=BASE_ADDR+word_idx*ADDR_STEP (32-bit, modulo 2^32),
//    mem_wdata=packed word; words_loaded=word_idx+1; word_idx==len-1 -> DONE, else word_idx++ -> DATA.
//    Write strobe registered: visible the cycle after the 4th byte transfer.
//  - DONE: done=1, cpu_nrst=1, in_ready=0; start -> HDR_LO with done=0, cpu_nrst=0, words_loaded=0.
//  - ERR: error=1, cpu_nrst=0, in_ready=0, no writes; start -> HDR_LO with error=0.
//  - start outside DONE/ERR ignored. mem_wen is 0 in every state except WRITE.
//  - Throughput: max 1 byte/cycle in DATA; 5 cycles/word minimum (4 bytes + WRITE).
// TESTING
//  1 Stream 02 00 78 56 34 12 EF BE AD DE, in_valid constant -> wen@0=0x12345678, wen@4=0xDEADBEEF,
//    exactly 2 strobes, done=1, cpu_nrst=1, words_loaded=2.
//  2 Same stream with in_valid randomly deasserted (~50%) -> identical writes and final state.
//  3 Header 00 00 -> DONE right after 2nd byte, zero strobes, cpu_nrst=1.
//  4 Header 01 01 (257>MAX_WORDS) -> error=1, cpu_nrst=0, no strobes, in_ready=0; start -> HDR_LO, error=0.
//  5 nrst pulsed after 2 of 4 data bytes -> no strobe, state HDR_LO, all outputs at reset values;
//    fresh stream then loads correctly from BASE_ADDR.
//  6 After test 1, start then 01 00 44 33 22 11 -> cpu_nrst low during load, one write 0x11223344 @0, done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the loader itself; the slave side is the host byte source plus the memory.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_waddr, mem_wdata, mem_wen
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_waddr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: takes a length-prefixed little-endian byte stream,
// packs it into 32-bit words and holds the core in reset until the whole image is written.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    imem_loader_if.master       bus,
    output logic                cpu_nrst,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_loaded
);

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [31:0] word_q, word_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_waddr_q, mem_waddr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        xfer_s;
    logic [15:0] hdr_len_s;

    // Byte acceptance depends only on the registered state, never on in_valid.
    assign bus.in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
    assign xfer_s       = bus.in_valid && bus.in_ready;
    assign hdr_len_s    = {bus.in_data, len_q[7:0]};

    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign words_loaded  = words_loaded_q;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
    assign cpu_nrst      = (state_q == S_DONE);

    // Next-state and datapath: the write strobe is prepared on the 4th byte so it is seen in WRITE.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        word_d         = word_q;
        mem_wen_d      = 1'b0;
        mem_waddr_d    = mem_waddr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_HDR_LO: begin
                if (xfer_s) begin
                    len_d   = {8'h00, bus.in_data};
                    state_d = S_HDR_HI;
                end else begin
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_HI: begin
                if (xfer_s) begin
                    len_d          = hdr_len_s;
                    byte_cnt_d     = 2'd0;
                    word_idx_d     = 16'd0;
                    words_loaded_d = 16'd0;
                    if (hdr_len_s == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_len_s) > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_HDR_HI;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    word_d[8*byte_cnt_q +: 8] = bus.in_data;
                    if (byte_cnt_q == 2'd3) begin
                        mem_wen_d      = 1'b1;
                        mem_waddr_d    = BASE_ADDR + (32'(word_idx_q) * 32'(ADDR_STEP));
                        mem_wdata_d    = word_d;
                        words_loaded_d = word_idx_q + 16'd1;
                        byte_cnt_d     = 2'd0;
                        state_d        = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                if (word_idx_q == (len_q - 16'd1)) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 16'd1;
                    state_d    = S_DATA;
                end
            end
            S_DONE: begin
                if (start) begin
                    words_loaded_d = 16'd0;
                    state_d        = S_HDR_LO;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_HDR_LO;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_HDR_LO;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= S_HDR_LO;
            len_q          <= 16'd0;
            byte_cnt_q     <= 2'd0;
            word_idx_q     <= 16'd0;
            word_q         <= 32'd0;
            mem_wen_q      <= 1'b0;
            mem_waddr_q    <= 32'd0;
            mem_wdata_q    <= 32'd0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            word_q         <= word_d;
            mem_wen_q      <= mem_wen_d;
            mem_waddr_q    <= mem_waddr_d;
            mem_wdata_q    <= mem_wdata_d;
            words_loaded_q <= words_loaded_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks writes and status outputs.
module tb_imem_loader;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        cpu_nrst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader_if bus ();

    imem_loader dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .bus          (bus),
        .cpu_nrst     (cpu_nrst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe (one cycle wide, so one negedge sample each).
    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) begin
            wr_addr.push_back(bus.mem_waddr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted; called at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("byte_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    logic [7:0] img1[10];
    logic [31:0] nwr;

    initial begin
        img1 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        nrst = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_wen",   {31'd0, bus.mem_wen}, 32'd0);
        check("rst_waddr", bus.mem_waddr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_cpu",   {31'd0, cpu_nrst}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, error}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        nrst = 1'b1;
        @(negedge clk);

        // Test 1: two words, in_valid constant
        clear_log();
        for (int i = 0; i < 2; i++) send_byte(img1[i], 0);
        check("t1_cpu_hold", {31'd0, cpu_nrst}, 32'd0);
        for (int i = 2; i < 10; i++) send_byte(img1[i], 0);
        wait_done();
        nwr = 32'(wr_addr.size());
        check("t1_nwr", nwr, 32'd2);
        if (nwr == 32'd2) begin
            check("t1_a0", wr_addr[0], 32'h0);
            check("t1_d0", wr_data[0], 32'h12345678);
            check("t1_a1", wr_addr[1], 32'h4);
            check("t1_d1", wr_data[1], 32'hDEADBEEF);
        end
        check("t1_cpu",   {31'd0, cpu_nrst}, 32'd1);
        check("t1_words", {16'd0, words_loaded}, 32'd2);
        check("t1_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t1_wen",   {31'd0, bus.mem_wen}, 32'd0);

        // Test 6: re-arm and load a one-word image
        pulse_start();
        check("t6_done0",  {31'd0, done}, 32'd0);
        check("t6_cpu0",   {31'd0, cpu_nrst}, 32'd0);
        check("t6_words0", {16'd0, words_loaded}, 32'd0);
        clear_log();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0);
        check("t6_cpu_hold", {31'd0, cpu_nrst}, 32'd0);
        send_byte(8'h11, 0);
        wait_done();
        nwr = 32'(wr_addr.size());
        check("t6_nwr", nwr, 32'd1);
        if (nwr == 32'd1) begin
            check("t6_a0", wr_addr[0], 32'h0);
            check("t6_d0", wr_data[0], 32'h11223344);
        end
        check("t6_words", {16'd0, words_loaded}, 32'd1);

        // Test 2: same image as test 1 with random idle gaps
        pulse_start();
        clear_log();
        for (int i = 0; i < 10; i++) send_byte(img1[i], int'($urandom_range(0, 2)));
        wait_done();
        nwr = 32'(wr_addr.size());
        check("t2_nwr", nwr, 32'd2);
        if (nwr == 32'd2) begin
            check("t2_a0", wr_addr[0], 32'h0);
            check("t2_d0", wr_data[0], 32'h12345678);
            check("t2_a1", wr_addr[1], 32'h4);
            check("t2_d1", wr_data[1], 32'hDEADBEEF);
        end
        check("t2_cpu",   {31'd0, cpu_nrst}, 32'd1);
        check("t2_words", {16'd0, words_loaded}, 32'd2);

        // Test 3: empty image completes straight after the header
        pulse_start();
        clear_log();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_cpu",  {31'd0, cpu_nrst}, 32'd1);
        repeat (2) @(negedge clk);
        check("t3_nwr", 32'(wr_addr.size()), 32'd0);

        // Test 4: 257 words exceeds the limit
        pulse_start();
        clear_log();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        repeat (2) @(negedge clk);
        check("t4_err",   {31'd0, error}, 32'd1);
        check("t4_cpu",   {31'd0, cpu_nrst}, 32'd0);
        check("t4_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t4_done",  {31'd0, done}, 32'd0);
        check("t4_nwr",   32'(wr_addr.size()), 32'd0);
        pulse_start();
        check("t4_err_clr", {31'd0, error}, 32'd0);
        check("t4_ready1",  {31'd0, bus.in_ready}, 32'd1);

        // Test 5: 256 words is accepted; reset mid-word discards the partial word
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        check("t5_max_ok",  {31'd0, error}, 32'd0);
        check("t5_in_data", {31'd0, bus.in_ready}, 32'd1);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        pulse_start();
        check("t5_start_ign", {31'd0, bus.in_ready}, 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("t5_wen",   {31'd0, bus.mem_wen}, 32'd0);
        check("t5_waddr", bus.mem_waddr, 32'h0);
        check("t5_wdata", bus.mem_wdata, 32'h0);
        check("t5_cpu",   {31'd0, cpu_nrst}, 32'd0);
        check("t5_words", {16'd0, words_loaded}, 32'd0);
        check("t5_nwr",   32'(wr_addr.size()), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h04, 0); send_byte(8'h03, 0); send_byte(8'h02, 0); send_byte(8'h01, 0);
        wait_done();
        nwr = 32'(wr_addr.size());
        check("t5_nwr2", nwr, 32'd1);
        if (nwr == 32'd1) begin
            check("t5_a0", wr_addr[0], 32'h0);
            check("t5_d0", wr_data[0], 32'h01020304);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
